alu_control_seq: RTL and testbench

//   Parametrised successor of the ALU control decoder. It decodes the 6-bit funct field and

---
 rtl/alu_control_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_control_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// alu_control_seq
// Decodes the instruction funct field into a single registered op code shared by
// the ALU, shifter, divider/multiplier and result mux. DIVU/MULTU are run through
// a counter FSM. When they finish, a one-cycle HiLo write is issued. Codes that are
// not supported are flagged with a one-cycle illegal pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready; a valid funct is accepted on every edge
// S_RUN   | divider/multiplier busy; cnt counts 0..N-1
// S_WRITE | one cycle: HiLo write enable, done, op_sel = 6'b111111
module alu_control_seq #(
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] funct,
    input  logic       funct_valid,
    output logic [5:0] op_sel,
    output logic       div_start,
    output logic       mul_start,
    output logic       hilo_we,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] OP_HILO = 6'b111111;
    localparam logic [5:0] OP_NONE = 6'b000000;

    // Last count value of RUN for each unit; RUN exits on the edge where cnt hits it.
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] last, last_nxt;
    logic [5:0]       op_nxt;
    logic             div_start_nxt;
    logic             mul_start_nxt;
    logic             hilo_we_nxt;
    logic             done_nxt;
    logic             illegal_nxt;

    logic             is_single;
    logic             is_div;
    logic             is_mul;
    logic             accept;

    // Classify the presented funct code.
    always_comb begin
        is_single = 1'b0;
        is_div    = 1'b0;
        is_mul    = 1'b0;
        case (funct)
            F_AND, F_OR, F_ADD, F_SUB,
            F_SLT, F_SRL, F_MFHI, F_MFLO: is_single = 1'b1;
            F_DIVU:                       is_div    = 1'b1;
            F_MULTU:                      is_mul    = 1'b1;
            default:                      ;
        endcase
    end

    // funct is only sampled while idle; busy drops the request without queueing it.
    assign accept = (state == S_IDLE) && funct_valid;
    assign busy   = (state != S_IDLE);

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_nxt      = last;
        op_nxt        = op_sel;
        div_start_nxt = 1'b0;
        mul_start_nxt = 1'b0;
        hilo_we_nxt   = 1'b0;
        done_nxt      = 1'b0;
        illegal_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_div) begin
                        state_nxt     = S_RUN;
                        cnt_nxt       = '0;
                        last_nxt      = DIV_LAST;
                        op_nxt        = funct;
                        div_start_nxt = 1'b1;
                    end else if (is_mul) begin
                        state_nxt     = S_RUN;
                        cnt_nxt       = '0;
                        last_nxt      = MUL_LAST;
                        op_nxt        = funct;
                        mul_start_nxt = 1'b1;
                    end else if (is_single) begin
                        op_nxt   = funct;
                        done_nxt = 1'b1;
                    end else begin
                        op_nxt      = OP_NONE;
                        illegal_nxt = 1'b1;
                        done_nxt    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Hold the counter on the exit edge so it can never wrap.
                if (cnt == last) begin
                    state_nxt   = S_WRITE;
                    op_nxt      = OP_HILO;
                    hilo_we_nxt = 1'b1;
                    done_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
                op_nxt    = OP_NONE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                op_nxt    = OP_NONE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and output registers; reset drops any instruction in flight silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last      <= '0;
            op_sel    <= OP_NONE;
            div_start <= 1'b0;
            mul_start <= 1'b0;
            hilo_we   <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            op_sel    <= op_nxt;
            div_start <= div_start_nxt;
            mul_start <= mul_start_nxt;
            hilo_we   <= hilo_we_nxt;
            done      <= done_nxt;
            illegal   <= illegal_nxt;
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq
// Two DUT instances share one stimulus stream: one uses long DIVU (32) and short
// MULTU (4), the other uses single-cycle units (1/1). A reference model turns each
// stimulus edge into expected completion, start and op_sel events. A monitor compares
// DUT outputs against those events every cycle.
module tb_alu_control_seq;

    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       funct_valid = 1'b0;
    logic [5:0] funct = 6'd0;

    logic [5:0] op0, op1;
    logic       ds0, ds1, ms0, ms1, hw0, hw1, busy0, busy1, dn0, dn1, il0, il1;

    alu_control_seq #(.DIV_CYCLES(32), .MUL_CYCLES(4), .CNT_W(6)) dut0 (
        .clk(clk), .reset(reset), .funct(funct), .funct_valid(funct_valid),
        .op_sel(op0), .div_start(ds0), .mul_start(ms0), .hilo_we(hw0),
        .busy(busy0), .done(dn0), .illegal(il0)
    );

    alu_control_seq #(.DIV_CYCLES(1), .MUL_CYCLES(1), .CNT_W(6)) dut1 (
        .clk(clk), .reset(reset), .funct(funct), .funct_valid(funct_valid),
        .op_sel(op1), .div_start(ds1), .mul_start(ms1), .hilo_we(hw1),
        .busy(busy1), .done(dn1), .illegal(il1)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; cycle c lies between edge c-1 and edge c.
    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        int         cyc;
        logic [5:0] op;
        logic       hilo;
        logic       ill;
    } done_t;

    typedef struct {
        int   cyc;
        logic is_div;
    } start_t;

    done_t      dq[2][$];
    start_t     sq[2][$];
    bit         chg_v[2][MAXC];
    logic [5:0] chg_val[2][MAXC];
    logic [5:0] cur_op[2];
    int         busy_lo[2];
    int         busy_hi[2];
    int         free_at[2];

    int n_checks = 0;
    int n_fail = 0;

    function automatic int div_n(int i);
        return (i == 0) ? 32 : 1;
    endfunction

    function automatic int mul_n(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit is_single(logic [5:0] f);
        return f inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18};
    endfunction

    task automatic chk(string name, int i, int c, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, i, c, act, exp);
        end
    endtask

    task automatic set_op(int i, int c, logic [5:0] v);
        chg_v[i][c] = 1'b1;
        chg_val[i][c] = v;
    endtask

    // Behavioural model: what this edge e does to instance i, in spec-cycle terms.
    task automatic model(int i, logic r, logic v, logic [5:0] f, int e);
        done_t  d;
        start_t s;
        int     n;
        if (r) begin
            while (dq[i].size() > 0 && dq[i][dq[i].size()-1].cyc > e) void'(dq[i].pop_back());
            while (sq[i].size() > 0 && sq[i][sq[i].size()-1].cyc > e) void'(sq[i].pop_back());
            if (busy_hi[i] > e) busy_hi[i] = e;
            for (int c = e + 1; c <= e + 40; c++) chg_v[i][c] = 1'b0;
            set_op(i, e + 1, 6'd0);
            free_at[i] = e + 1;
        end else if (v && e >= free_at[i]) begin
            if (f == 6'd27 || f == 6'd25) begin
                n = (f == 6'd27) ? div_n(i) : mul_n(i);
                s.cyc = e + 1;
                s.is_div = (f == 6'd27);
                sq[i].push_back(s);
                d.cyc = e + n + 1;
                d.op = 6'd63;
                d.hilo = 1'b1;
                d.ill = 1'b0;
                dq[i].push_back(d);
                set_op(i, e + 1, f);
                set_op(i, e + n + 1, 6'd63);
                set_op(i, e + n + 2, 6'd0);
                busy_lo[i] = e + 1;
                busy_hi[i] = e + n + 1;
                free_at[i] = e + n + 2;
            end else if (is_single(f)) begin
                d.cyc = e + 1;
                d.op = f;
                d.hilo = 1'b0;
                d.ill = 1'b0;
                dq[i].push_back(d);
                set_op(i, e + 1, f);
            end else begin
                d.cyc = e + 1;
                d.op = 6'd0;
                d.hilo = 1'b0;
                d.ill = 1'b1;
                dq[i].push_back(d);
                set_op(i, e + 1, 6'd0);
            end
        end
    endtask

    task automatic drive(logic r, logic v, logic [5:0] f);
        @(negedge clk);
        reset = r;
        funct_valid = v;
        funct = f;
        for (int i = 0; i < 2; i++) model(i, r, v, f, edge_no + 1);
    endtask

    // Monitor: compare every output of both instances against the model each cycle.
    initial begin
        done_t      d;
        start_t     s;
        logic [5:0] op;
        logic       ds, ms, hw, bz, dn, il;
        int         c;
        int         exp_busy;
        forever begin
            @(negedge clk);
            c = edge_no + 1;
            if (c >= 2) begin
                for (int i = 0; i < 2; i++) begin
                    if (i == 0) begin
                        op = op0; ds = ds0; ms = ms0; hw = hw0; bz = busy0; dn = dn0; il = il0;
                    end else begin
                        op = op1; ds = ds1; ms = ms1; hw = hw1; bz = busy1; dn = dn1; il = il1;
                    end
                    if (chg_v[i][c]) cur_op[i] = chg_val[i][c];
                    chk("op_sel", i, c, int'(op), int'(cur_op[i]));
                    exp_busy = (c >= busy_lo[i] && c <= busy_hi[i]) ? 1 : 0;
                    chk("busy", i, c, int'(bz), exp_busy);
                    if (dn) begin
                        if (dq[i].size() == 0) begin
                            chk("done_unexpected", i, c, int'(dn), 0);
                        end else begin
                            d = dq[i].pop_front();
                            chk("done_cycle", i, c, c, d.cyc);
                            chk("hilo_we_illegal", i, c, int'({hw, il}), int'({d.hilo, d.ill}));
                        end
                    end else begin
                        chk("pulse_without_done", i, c, int'({hw, il}), 0);
                        if (dq[i].size() > 0 && dq[i][0].cyc <= c) begin
                            chk("done_missing", i, c, int'(dn), 1);
                            void'(dq[i].pop_front());
                        end
                    end
                    if (ds || ms) begin
                        if (sq[i].size() == 0) begin
                            chk("start_unexpected", i, c, int'({ds, ms}), 0);
                        end else begin
                            s = sq[i].pop_front();
                            chk("start_cycle", i, c, c, s.cyc);
                            chk("start_kind", i, c, int'({ds, ms}), int'({s.is_div, ~s.is_div}));
                        end
                    end else if (sq[i].size() > 0 && sq[i][0].cyc <= c) begin
                        chk("start_missing", i, c, int'({ds, ms}), 1);
                        void'(sq[i].pop_front());
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized mix with occasional resets.
    initial begin
        logic [5:0] singles[8];
        logic [5:0] f;
        int         pick;
        singles = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18};
        for (int i = 0; i < 2; i++) begin
            busy_lo[i] = -1;
            busy_hi[i] = -1;
            free_at[i] = 0;
            cur_op[i] = 6'd0;
        end

        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 1, 6'd32);
        drive(0, 0, 0);

        drive(0, 1, 6'd36);
        drive(0, 1, 6'd37);
        drive(0, 1, 6'd34);
        drive(0, 1, 6'd42);
        drive(0, 0, 0);

        drive(0, 1, 6'd27);
        for (int k = 0; k < 36; k++) drive(0, 0, 6'(k));

        drive(0, 1, 6'd25);
        for (int k = 0; k < 8; k++) drive(0, 1, 6'd32);
        drive(0, 0, 0);

        drive(0, 1, 6'd27);
        for (int k = 0; k < 15; k++) drive(0, 0, 0);
        drive(1, 1, 6'd32);
        drive(0, 1, 6'd32);
        drive(0, 0, 0);

        drive(0, 1, 6'b000111);
        drive(0, 0, 0);
        drive(0, 1, 6'd63);
        drive(0, 1, 6'd27);
        for (int k = 0; k < 36; k++) drive(0, 1, 6'd25);
        for (int k = 0; k < 6; k++) drive(0, 0, 0);

        for (int k = 0; k < 1500; k++) begin
            pick = $urandom_range(0, 11);
            if (pick < 8) f = singles[pick];
            else if (pick == 8) f = 6'd27;
            else if (pick == 9) f = 6'd25;
            else f = 6'($urandom_range(0, 63));
            drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, f);
        end

        for (int k = 0; k < 40; k++) drive(0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("queue_drained", i, edge_no + 1, dq[i].size() + sq[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
